uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 5-8 data bits, optional odd/even parity, 1-2 stop bits.
// A completed frame is presented one clk after the final stop sample, with sticky overrun tracking.
module uart_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       rx,
  input  logic [1:0] data_bit_num,
  input  logic       stop_bit_num,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic       rx_rd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       rts_n
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  function automatic logic exp_parity(input logic [7:0] d, input logic even);
    return even ? (^d) : (~^d);
  endfunction

  state_t     state_r, state_nxt_s;
  logic       rx_meta_r, rx_sync_r;
  logic [3:0] tick_cnt_r;
  logic [3:0] bit_cnt_r;
  logic       stop_cnt_r;
  logic [7:0] shift_r;
  logic       par_bit_r;
  logic       frm_acc_r;
  logic       commit_r;
  logic [7:0] rx_data_r;
  logic       rx_valid_r, parity_err_r, frame_err_r, overrun_r, pending_r;

  logic [3:0] num_data_s, total_s;
  logic       sample_s, last_data_s, last_stop_s, commit_s, start_s;

  assign num_data_s = 4'd5 + {2'b00, data_bit_num};
  assign total_s    = num_data_s + {3'b000, parity_en};

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; transitions happen only on tick edges
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (tick && !rx_sync_r) state_nxt_s = START;
        else                    state_nxt_s = IDLE;
      end
      START: begin
        if (tick && tick_cnt_r == 4'd7) state_nxt_s = rx_sync_r ? IDLE : DATA;
        else                            state_nxt_s = START;
      end
      DATA: begin
        if (sample_s && last_data_s) state_nxt_s = STOP;
        else                         state_nxt_s = DATA;
      end
      STOP: begin
        if (sample_s && last_stop_s) state_nxt_s = IDLE;
        else                         state_nxt_s = STOP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output strobes
  always_comb begin
    sample_s    = tick && (tick_cnt_r == 4'd15) && (state_r == DATA || state_r == STOP);
    last_data_s = (bit_cnt_r == total_s - 4'd1);
    last_stop_s = (stop_cnt_r == stop_bit_num);
    commit_s    = sample_s && (state_r == STOP) && last_stop_s;
    start_s     = (state_r == IDLE) && (state_nxt_s == START);
  end

  // Bit-timing counter and frame assembly datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_r <= 4'd0;
      bit_cnt_r  <= 4'd0;
      stop_cnt_r <= 1'b0;
      shift_r    <= 8'h00;
      par_bit_r  <= 1'b0;
      frm_acc_r  <= 1'b0;
    end else if (tick) begin
      if (state_nxt_s != state_r || sample_s) tick_cnt_r <= 4'd0;
      else                                    tick_cnt_r <= tick_cnt_r + 4'd1;
      if (start_s) begin
        bit_cnt_r  <= 4'd0;
        stop_cnt_r <= 1'b0;
        shift_r    <= 8'h00;
        par_bit_r  <= 1'b0;
        frm_acc_r  <= 1'b0;
      end else if (sample_s && state_r == DATA) begin
        // Data bits land by index so unused upper bits stay zero
        if (bit_cnt_r < num_data_s) shift_r[bit_cnt_r[2:0]] <= rx_sync_r;
        else                        par_bit_r <= rx_sync_r;
        bit_cnt_r <= last_data_s ? 4'd0 : bit_cnt_r + 4'd1;
      end else if (sample_s && state_r == STOP) begin
        frm_acc_r  <= frm_acc_r | ~rx_sync_r;
        stop_cnt_r <= last_stop_s ? 1'b0 : stop_cnt_r + 1'b1;
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
    end else begin
      tick_cnt_r <= tick_cnt_r;
    end
  end

  // Commit strobe delayed one clk so the final stop sample is folded into frm_acc_r
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) commit_r <= 1'b0;
    else        commit_r <= commit_s;
  end

  // Registered frame results, held until the next commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_r    <= 8'h00;
      rx_valid_r   <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      rx_valid_r <= commit_r;
      if (commit_r) begin
        rx_data_r    <= shift_r;
        parity_err_r <= parity_en & (par_bit_r ^ exp_parity(shift_r, parity_type));
        frame_err_r  <= frm_acc_r;
      end else begin
        rx_data_r <= rx_data_r;
      end
    end
  end

  // Consumer handshake: pending and sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (commit_r)   pending_r <= 1'b1;
      else if (rx_rd) pending_r <= 1'b0;
      else            pending_r <= pending_r;
      if (commit_r && pending_r && !rx_rd) overrun_r <= 1'b1;
      else if (rx_rd)                      overrun_r <= 1'b0;
      else                                 overrun_r <= overrun_r;
    end
  end

  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign parity_err  = parity_err_r;
  assign frame_err   = frame_err_r;
  assign overrun_err = overrun_r;
  // Not-ready is forced while in reset, otherwise mirrors pending
  assign rts_n       = pending_r | ~rst_n;

endmodule
